// File: rtl/satagtx_rst_seq.sv
// -----------------------------------------------------------------------------
// satagtx_rst_seq
//
// Reset / bring-up sequencer for a GTX transceiver tile feeding a SATA link.
// It brings the tile out of reset in this order:
//   1. pulse the GTX tile reset,
//   2. wait for PLL lock,
//   3. wait for the user-clock DCM/PLL lock,
//   4. hold the TX/RX datapath resets while the clocks settle,
//   5. wait for both reset-done indications.
//
// Each wait state has a timeout. A timeout restarts the sequence. When too
// many timeouts occur in a row, the sequencer parks in a sticky FAIL state.
// If a clock lock is lost in a later state, the sequence restarts without
// counting a retry. Lock losses seen in READY are counted in relock_cnt.
//
// Ports
//   clk                   : free-running fabric clock; all logic runs on its
//                           rising edge
//   rst                   : synchronous, active-high reset
//   tile0_plllkdet        : GTX PLL lock (asynchronous)
//   refclkout_dcm0_locked : user-clock DCM/PLL lock (asynchronous)
//   txresetdone           : GTX TX reset done (asynchronous)
//   rxresetdone           : GTX RX reset done (asynchronous)
//   gtxreset              : GTX tile reset
//   dcm_reset             : user-clock DCM/PLL reset
//   txreset               : GTX TX datapath reset
//   rxreset               : GTX RX datapath reset
//   clk_ready             : clocks locked and both datapaths out of reset
//   seq_fail              : sticky; retries are exhausted
//   seq_state             : current state encoding
//   relock_cnt            : saturating count of lock losses seen in READY
// -----------------------------------------------------------------------------
module satagtx_rst_seq #(
    parameter int C_GTXRST_CYCLES = 8,
    parameter int C_SETTLE_CYCLES = 16,
    parameter int C_TIMEOUT       = 1024,
    parameter int C_MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tile0_plllkdet,
    input  logic       refclkout_dcm0_locked,
    input  logic       txresetdone,
    input  logic       rxresetdone,
    output logic       gtxreset,
    output logic       dcm_reset,
    output logic       txreset,
    output logic       rxreset,
    output logic       clk_ready,
    output logic       seq_fail,
    output logic [2:0] seq_state,
    output logic [7:0] relock_cnt
);

    typedef enum logic [2:0] {
        RESET_GTX = 3'd0,
        WAIT_PLL  = 3'd1,
        WAIT_DCM  = 3'd2,
        USR_RST   = 3'd3,
        WAIT_DONE = 3'd4,
        READY     = 3'd5,
        FAIL      = 3'd6
    } state_t;

    localparam logic [15:0] GTXRST_LAST  = 16'(C_GTXRST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST  = 16'(C_SETTLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(C_TIMEOUT - 1);
    localparam logic [8:0]  RETRY_LIMIT  = 9'(C_MAX_RETRY);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [7:0]  retry_cnt;
    logic [8:0]  retry_new;
    logic        timeout_hit;
    logic        lock_lost;

    logic [3:0]  async_in;
    logic [3:0]  sync_p0;
    logic [3:0]  sync_p1;
    logic        pll_ok;
    logic        dcm_ok;
    logic        tx_done;
    logic        rx_done;

    logic        gtxreset_nxt;
    logic        dcm_reset_nxt;
    logic        txreset_nxt;
    logic        rxreset_nxt;

    // Stage p0/p1: two-flop synchronizers for the asynchronous status inputs
    assign async_in = {rxresetdone, txresetdone, refclkout_dcm0_locked, tile0_plllkdet};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
        end
    end

    assign pll_ok  = sync_p1[0];
    assign dcm_ok  = sync_p1[1];
    assign tx_done = sync_p1[2];
    assign rx_done = sync_p1[3];

    // Next-state logic. A lock loss overrides everything else. A state's
    // exit condition is tested before its timeout, so an exit that happens
    // on the timeout cycle itself still counts as success.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        lock_lost   = 1'b0;
        retry_new   = {1'b0, retry_cnt} + 9'd1;

        case (state)
            RESET_GTX: begin
                if (cnt == GTXRST_LAST) state_nxt = WAIT_PLL;
            end
            WAIT_PLL: begin
                if (pll_ok)                    state_nxt   = WAIT_DCM;
                else if (cnt == TIMEOUT_LAST)  timeout_hit = 1'b1;
            end
            WAIT_DCM: begin
                if (!pll_ok)                   lock_lost   = 1'b1;
                else if (dcm_ok)               state_nxt   = USR_RST;
                else if (cnt == TIMEOUT_LAST)  timeout_hit = 1'b1;
            end
            USR_RST: begin
                if (!pll_ok || !dcm_ok)        lock_lost   = 1'b1;
                else if (cnt == SETTLE_LAST)   state_nxt   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!pll_ok || !dcm_ok)        lock_lost   = 1'b1;
                else if (tx_done && rx_done)   state_nxt   = READY;
                else if (cnt == TIMEOUT_LAST)  timeout_hit = 1'b1;
            end
            READY: begin
                if (!pll_ok || !dcm_ok)        lock_lost   = 1'b1;
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = RESET_GTX;
            end
        endcase

        if (lock_lost) begin
            state_nxt = RESET_GTX;
        end else if (timeout_hit) begin
            state_nxt = (retry_new > RETRY_LIMIT) ? FAIL : RESET_GTX;
        end
    end

    // The outputs are decoded from the next state and registered, so they
    // change on the same edge as seq_state.
    always_comb begin
        gtxreset_nxt  = 1'b0;
        dcm_reset_nxt = 1'b0;
        txreset_nxt   = 1'b1;
        rxreset_nxt   = 1'b1;
        case (state_nxt)
            RESET_GTX, FAIL: begin
                gtxreset_nxt  = 1'b1;
                dcm_reset_nxt = 1'b1;
            end
            WAIT_PLL: begin
                dcm_reset_nxt = 1'b1;
            end
            WAIT_DONE, READY: begin
                txreset_nxt   = 1'b0;
                rxreset_nxt   = 1'b0;
            end
            default: begin
                txreset_nxt   = 1'b1;
                rxreset_nxt   = 1'b1;
            end
        endcase
    end

    // Stage state: state, counter, retry/relock bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_GTX;
            cnt        <= '0;
            retry_cnt  <= '0;
            relock_cnt <= '0;
            gtxreset   <= 1'b1;
            dcm_reset  <= 1'b1;
            txreset    <= 1'b1;
            rxreset    <= 1'b1;
            clk_ready  <= 1'b0;
            seq_fail   <= 1'b0;
        end else begin
            state <= state_nxt;

            // The counter restarts on every state change and holds at
            // all-ones instead of wrapping in long-lived states.
            if (state_nxt != state)   cnt <= '0;
            else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;

            if (state_nxt == READY)   retry_cnt <= '0;
            else if (timeout_hit)     retry_cnt <= retry_new[7:0];

            if (lock_lost && (state == READY) && (relock_cnt != 8'hFF))
                relock_cnt <= relock_cnt + 8'd1;

            gtxreset  <= gtxreset_nxt;
            dcm_reset <= dcm_reset_nxt;
            txreset   <= txreset_nxt;
            rxreset   <= rxreset_nxt;
            clk_ready <= (state_nxt == READY);
            seq_fail  <= seq_fail | (state_nxt == FAIL);
        end
    end

    assign seq_state = state;

endmodule

// File: doc/satagtx_rst_seq.md
SATAGTX_RST_SEQ -- requirements
Module: satagtx_rst_seq

Interface
REQ-001 SHALL have parameter C_GTXRST_CYCLES, default 8: cycles GTX reset is held asserted.
REQ-002 SHALL have parameter C_SETTLE_CYCLES, default 16: cycles TX/RX user resets are held after clocks are stable.
REQ-003 SHALL have parameter C_TIMEOUT, default 1024, range 2..65535: maximum cycles spent in any wait state.
REQ-004 SHALL have parameter C_MAX_RETRY, default 3: timeouts tolerated before entering FAIL.
REQ-005 SHALL have port clk, input, 1: the single clock (free-running fabric clock); all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port tile0_plllkdet, input, 1: GTX PLL lock, asynchronous to clk.
REQ-008 SHALL have port refclkout_dcm0_locked, input, 1: user-clock DCM/PLL lock, asynchronous to clk.
REQ-009 SHALL have port txresetdone, input, 1: GTX TX reset done, asynchronous to clk.
REQ-010 SHALL have port rxresetdone, input, 1: GTX RX reset done, asynchronous to clk.
REQ-011 SHALL have port gtxreset, output, 1: GTX tile reset.
REQ-012 SHALL have port dcm_reset, output, 1: user-clock DCM/PLL reset.
REQ-013 SHALL have port txreset, output, 1: GTX TX datapath reset.
REQ-014 SHALL have port rxreset, output, 1: GTX RX datapath reset.
REQ-015 SHALL have port clk_ready, output, 1: high when all clocks are locked and both datapaths are out of reset.
REQ-016 SHALL have port seq_fail, output, 1: sticky; retries are exhausted.
REQ-017 SHALL have port seq_state, output, 3: current state encoding.
REQ-018 SHALL have port relock_cnt, output, 8: count of lock losses seen in READY.

Function
REQ-019 SHALL synchronize every asynchronous input through 2 flops before use, adding 2 cycles of latency.
REQ-020 SHALL implement states RESET_GTX=0, WAIT_PLL=1, WAIT_DCM=2, USR_RST=3, WAIT_DONE=4, READY=5, FAIL=6.
REQ-021 SHALL drive all outputs from registers, decoded from the state and counter registers.
REQ-022 SHALL use a 16-bit counter, cleared on every state entry and incremented each cycle in the state.
REQ-023 SHALL, in RESET_GTX: gtxreset=1, dcm_reset=1, txreset=1, rxreset=1; go to WAIT_PLL when counter = C_GTXRST_CYCLES-1.
REQ-024 SHALL, in WAIT_PLL: dcm_reset=1, txreset=1, rxreset=1; go to WAIT_DCM when synchronized plllkdet=1.
REQ-025 SHALL, in WAIT_DCM: txreset=1, rxreset=1; go to USR_RST when synchronized dcm_locked=1.
REQ-026 SHALL, in USR_RST: txreset=1, rxreset=1; go to WAIT_DONE when counter = C_SETTLE_CYCLES-1.
REQ-027 SHALL, in WAIT_DONE: all resets=0; go to READY when both synchronized resetdone inputs = 1.
REQ-028 SHALL, in READY: clk_ready=1 and retry count cleared to 0.
REQ-029 SHALL treat the counter reaching C_TIMEOUT-1 in WAIT_PLL, WAIT_DCM or WAIT_DONE, with the exit condition false, as a timeout.
REQ-030 SHALL, on timeout, increment the 2-bit-or-wider retry count; go to FAIL if the new count > C_MAX_RETRY, else to RESET_GTX.
REQ-031 SHALL give the exit condition priority over timeout when both occur in the same cycle.
REQ-032 SHALL return to RESET_GTX, without incrementing retry, when synchronized plllkdet=0 in WAIT_DCM, USR_RST, WAIT_DONE or READY.
REQ-033 SHALL return to RESET_GTX when synchronized dcm_locked=0 in USR_RST, WAIT_DONE or READY.
REQ-034 SHALL give lock loss (REQ-032/033) priority over all other transitions.
REQ-035 SHALL increment relock_cnt, saturating at 255, only for lock loss occurring in READY.
REQ-036 SHALL, in FAIL: gtxreset=1, dcm_reset=1, txreset=1, rxreset=1, seq_fail=1; leave FAIL only on rst.

Reset
REQ-037 SHALL, on rst=1, enter RESET_GTX with counter=0, retry=0, relock_cnt=0, seq_fail=0, clk_ready=0, and all resets=1 on the following cycle.
REQ-038 SHALL clear the synchronizer flops to 0 on rst, and rst asserted mid-sequence SHALL restart the sequence from RESET_GTX.

Verification
REQ-039 SHALL verify normal bring-up: locks and resetdones assert 10 cycles after release -> gtxreset high exactly 8 cycles, clk_ready=1, seq_state=5.
REQ-040 SHALL verify PLL timeout: plllkdet held 0 -> 4 timeouts of 1024 cycles each, then seq_fail=1, seq_state=6, held until rst.
REQ-041 SHALL verify lock loss in READY: plllkdet drops for 1 cycle -> seq_state=0 within 3 cycles, relock_cnt=1, and re-reaches READY after relock.
REQ-042 SHALL verify exit/timeout collision: dcm_locked rises on the exact timeout cycle -> USR_RST entered, retry count unchanged.
REQ-043 SHALL verify mid-sequence reset: rst asserted in WAIT_DONE -> next cycle seq_state=0, all resets=1, relock_cnt=0.
REQ-044 SHALL verify retry recovery: 2 DCM timeouts then lock -> READY reached, seq_fail=0, retry cleared.
